// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB predictor with 2-bit counters plus resolve, flush and link logic; BPU_PERF_CNT_EN adds perf counters
module branch_predict_unit #(
    parameter int WIDTH     = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] f_pc,
    output logic             f_pred_taken,
    output logic [WIDTH-1:0] f_pred_target,
    input  logic             r_valid,
    input  logic [31:0]      r_instr,
    input  logic [WIDTH-1:0] r_pc,
    input  logic [WIDTH-1:0] r_rs1,
    input  logic             r_pred_taken,
    input  logic [WIDTH-1:0] r_pred_target,
    output logic             take_branch,
    output logic [WIDTH-1:0] branch_target,
    output logic             flush,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             link_we,
    output logic [WIDTH-1:0] link_data
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispredicts
`endif
);
    localparam int IDX = $clog2(BTB_DEPTH);
    localparam int TAG = WIDTH - IDX - 2;
    logic [BTB_DEPTH-1:0] btb_valid;
    logic [TAG-1:0]       btb_tag    [BTB_DEPTH];
    logic [WIDTH-1:0]     btb_target [BTB_DEPTH];
    logic [1:0]           btb_ctr    [BTB_DEPTH];
    logic [IDX-1:0]   f_idx, r_idx;
    logic [TAG-1:0]   r_tag;
    logic             f_hit, r_hit;
    logic [5:0]       op;
    logic             is_jump, is_cond, is_br, is_link, is_reg, taken, mispredict, accept;
    logic [WIDTH-1:0] pc4, off, target;
    logic [1:0]       cur_ctr, new_ctr;
    assign f_idx         = f_pc[IDX+1:2];
    assign f_hit         = btb_valid[f_idx] && btb_tag[f_idx] == f_pc[WIDTH-1:IDX+2];
    assign f_pred_taken  = f_hit && btb_ctr[f_idx][1];
    assign f_pred_target = f_pred_taken ? btb_target[f_idx] : f_pc + WIDTH'(4);
    assign op         = r_instr[31:26];
    assign is_link    = op == 6'h03 || op == 6'h13;
    assign is_reg     = op == 6'h12 || op == 6'h13;
    assign is_jump    = op == 6'h02 || is_link || op == 6'h12;
    assign is_cond    = op == 6'h04 || op == 6'h05;
    assign is_br      = is_jump || is_cond;
    assign pc4        = r_pc + WIDTH'(4);
    assign off        = is_cond ? {{(WIDTH-16){r_instr[15]}}, r_instr[15:0]} : {{(WIDTH-26){r_instr[25]}}, r_instr[25:0]};
    assign target     = is_reg ? r_rs1 : pc4 + off;
    assign taken      = is_jump || (op == 6'h04 && r_rs1 == '0) || (op == 6'h05 && r_rs1 != '0);
    assign mispredict = (r_pred_taken != taken) || (taken && r_pred_target != target);
    // the cycle after a mispredict is wrong-path and must be ignored
    assign accept     = r_valid && !flush;
    assign r_idx      = r_pc[IDX+1:2];
    assign r_tag      = r_pc[WIDTH-1:IDX+2];
    assign r_hit      = btb_valid[r_idx] && btb_tag[r_idx] == r_tag;
    assign cur_ctr    = btb_ctr[r_idx];
    assign new_ctr    = is_jump ? 2'b11 : !r_hit ? 2'b10 : taken ? (cur_ctr == 2'b11 ? cur_ctr : cur_ctr + 2'b01) : (cur_ctr == 2'b00 ? cur_ctr : cur_ctr - 2'b01);
    // BTB training: allocate on taken miss, adjust counter on hit
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) btb_ctr[i] <= 2'b01;
        end else if (accept && is_br && (r_hit || taken)) begin
            btb_valid[r_idx] <= 1'b1;
            btb_tag[r_idx]   <= r_tag;
            btb_ctr[r_idx]   <= new_ctr;
            if (taken) btb_target[r_idx] <= target;
        end
    end
    // registered resolve results; everything reads 0 when nothing was accepted
    always_ff @(posedge clk) begin
        if (reset || !accept) begin
            take_branch   <= 1'b0;
            branch_target <= '0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            link_we       <= 1'b0;
            link_data     <= '0;
        end else begin
            take_branch   <= taken;
            branch_target <= is_br ? target : '0;
            flush         <= mispredict;
            redirect_pc   <= mispredict ? (taken ? target : pc4) : '0;
            link_we       <= is_link;
            link_data     <= is_link ? pc4 : '0;
        end
    end
`ifdef BPU_PERF_CNT_EN
    // saturating event counters for accepted branches and flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (accept) begin
            if (is_br && perf_branches != 32'hFFFFFFFF) perf_branches <= perf_branches + 32'd1;
            if (mispredict && perf_mispredicts != 32'hFFFFFFFF) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif
endmodule
